seg7_display_ctrl: RTL and testbench
====================================

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 Parameter NUM_FIELDS, default 4: number of independent decimal fields shown.
REQ-002 Parameter DIGITS_PER_FIELD, default 2: decimal digits per field.
REQ-003 Parameter DATA_W, default 32: width of each unsigned field value.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  request to capture field_val and start a conversion.
REQ-007 field_val  input  NUM_FIELDS*DATA_W  field f at bits [f*DATA_W +: DATA_W], unsigned.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse on the cycle seg is updated.
REQ-010 seg  output  NUM_FIELDS*DIGITS_PER_FIELD*7  active-low segments, bits {g,f,e,d,c,b,a}; field f, digit d (d=0 least significant) at [(f*DIGITS_PER_FIELD+d)*7 +: 7].

Function
REQ-011 FSM states: IDLE, CONV, COMMIT; only IDLE accepts load.
REQ-012 IDLE with load=1 at edge N: capture all field_val into shadow registers, clear BCD accumulators, enter CONV; busy=1 from edge N.
REQ-013 CONV: shift-add-3 (double dabble), one input bit per cycle, MSB first, fields converted in order 0..NUM_FIELDS-1; DATA_W cycles per field.
REQ-014 Each BCD accumulator is DIGITS_PER_FIELD*4 bits; per-field overflow flag sets when a 1 is shifted out of the accumulator MSB.
REQ-015 After NUM_FIELDS*DATA_W CONV cycles enter COMMIT; at that edge seg for all fields updates together, done=1 for one cycle, busy=0, return to IDLE.
REQ-016 Latency: load sampled at edge N -> seg/done at edge N+NUM_FIELDS*DATA_W+1; defaults give 129 cycles.
REQ-017 seg holds its last committed value during CONV; no partial updates.
REQ-018 Digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
REQ-019 Overflow field (value >= 10^DIGITS_PER_FIELD) shows dash on every digit of that field; other fields are unaffected.
REQ-020 load while busy=1 is ignored; it is not queued.
REQ-021 load asserted on the COMMIT edge is ignored; load in the following IDLE cycle is accepted.
REQ-022 field_val changes after capture do not affect the running conversion.

Reset
REQ-023 rst_n=0 asynchronously forces FSM=IDLE, busy=0, done=0, shadow and BCD registers=0, every seg digit=1000000 ("0").
REQ-024 Reset during CONV aborts the conversion; seg returns to all-"0", and no done pulse is issued.
REQ-025 Operation resumes on the first clk edge after rst_n deasserts.

Configuration
REQ-026 Macro SEG7_BLANK_LEADING_ZERO_EN defined: within each non-overflow field, zero digits above the most significant nonzero digit show blank; digit 0 is never blanked (value 0 shows blank..blank,"0").
REQ-027 Macro undefined: all digits show their numeral, including leading zeros. The reset value (all "0") is identical in both builds.

Verification (defaults)
REQ-028 Reset, then load with field_val={0,99,42,7} (field3..field0) at edge N -> edge N+129: done=1 for one cycle; seg digit pairs (field3..0) "00","99","42","07"; busy=1 between these edges.
REQ-029 Load field0=100, field1=12345, field2=10, field3=9 -> field0 and field1 all dash; field2 "10"; field3 "09"; fields 2 and 3 unaffected by the overflows.
REQ-030 Load A, then assert load with different values at cycles +5 and +128 -> seg reflects A only, exactly one done pulse; a load one cycle after done starts a new conversion.
REQ-031 Commit 42s, load 17s, assert rst_n=0 at cycle +60 -> seg all "0" immediately; busy=0; no done pulse.
REQ-032 With SEG7_BLANK_LEADING_ZERO_EN: load {0,5,10,99} -> field3 blank,"0"; field2 blank,"5"; field1 "10"; field0 "99"; without the macro field2 shows "05".

Source files
------------

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: converts NUM_FIELDS unsigned binary fields to BCD with a
// serial shift-add-3 engine (one bit per clock, field 0 first) and drives
// active-low 7-segment patterns for every digit once all fields are done.
// Fields too large for DIGITS_PER_FIELD digits show a dash on every digit.
// Optional build macro: SEG7_BLANK_LEADING_ZERO_EN -- blank leading zero
// digits of non-overflow fields (digit 0 is always shown).
module seg7_display_ctrl #(
    parameter int NUM_FIELDS       = 4,
    parameter int DIGITS_PER_FIELD = 2,
    parameter int DATA_W           = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     load,
    input  logic [NUM_FIELDS*DATA_W-1:0]             field_val,
    output logic                                     busy,
    output logic                                     done,
    output logic [NUM_FIELDS*DIGITS_PER_FIELD*7-1:0] seg
);

    localparam int BCD_W = DIGITS_PER_FIELD * 4;
    localparam int SEG_W = NUM_FIELDS * DIGITS_PER_FIELD * 7;
    localparam int FLD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [FLD_W-1:0] FLD_LAST = FLD_W'(NUM_FIELDS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]                               r_state;
    logic [NUM_FIELDS-1:0][DATA_W-1:0]        r_shadow;
    logic [NUM_FIELDS-1:0][BCD_W-1:0]         r_bcd;
    logic [NUM_FIELDS-1:0]                    r_ovf;
    logic [FLD_W-1:0]                         r_fld;
    logic [BIT_W-1:0]                         r_bit;
    logic [SEG_W-1:0]                         r_seg;
    logic                                     r_done;

    logic [BCD_W-1:0]                         w_cur;
    logic [BCD_W-1:0]                         w_adj;
    logic [BCD_W-1:0]                         w_shifted;
    logic                                     w_carry;
    logic [SEG_W-1:0]                         w_seg_next;
    logic [3:0]                               w_dig;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    logic                                     w_lead;
`endif

    // All-"0" pattern used on reset, independent of the blanking option.
    function automatic logic [SEG_W-1:0] seg_all_zero();
        logic [SEG_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_FIELDS * DIGITS_PER_FIELD; i++) v[i*7 +: 7] = SEG_ZERO;
        return v;
    endfunction

    // BCD digit to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        case (v)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step on the field being converted: add 3 to digits
    // >= 5, then shift in the next MSB; the bit leaving the top is overflow.
    always_comb begin
        w_cur = r_bcd[r_fld];
        w_adj = '0;
        for (int d = 0; d < DIGITS_PER_FIELD; d++) begin
            if (w_cur[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = w_cur[d*4 +: 4] + 4'd3;
            else                         w_adj[d*4 +: 4] = w_cur[d*4 +: 4];
        end
        {w_carry, w_shifted} = {w_adj, r_shadow[r_fld][DATA_W-1]};
    end

    // Segment image for all fields, built from the finished accumulators.
    always_comb begin
        w_seg_next = '0;
        w_dig      = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
`ifdef SEG7_BLANK_LEADING_ZERO_EN
            w_lead = 1'b1;
`endif
            for (int d = DIGITS_PER_FIELD - 1; d >= 0; d--) begin
                w_dig = r_bcd[f][d*4 +: 4];
                if (r_ovf[f]) begin
                    w_seg_next[(f*DIGITS_PER_FIELD+d)*7 +: 7] = SEG_DASH;
                end else begin
`ifdef SEG7_BLANK_LEADING_ZERO_EN
                    // w_lead stays high while every digit so far is zero.
                    w_lead = w_lead & (w_dig == 4'd0);
                    if (w_lead && (d != 0))
                        w_seg_next[(f*DIGITS_PER_FIELD+d)*7 +: 7] = SEG_BLANK;
                    else
                        w_seg_next[(f*DIGITS_PER_FIELD+d)*7 +: 7] = seg_enc(w_dig);
`else
                    w_seg_next[(f*DIGITS_PER_FIELD+d)*7 +: 7] = seg_enc(w_dig);
`endif
                end
            end
        end
    end

    // Control FSM: capture on load in IDLE, one bit per CONV cycle, then a
    // single COMMIT cycle that updates every field at once and pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_bcd    <= '0;
            r_ovf    <= '0;
            r_fld    <= '0;
            r_bit    <= '0;
            r_seg    <= seg_all_zero();
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shadow <= field_val;
                        r_bcd    <= '0;
                        r_ovf    <= '0;
                        r_fld    <= '0;
                        r_bit    <= '0;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd[r_fld]    <= w_shifted;
                    r_ovf[r_fld]    <= r_ovf[r_fld] | w_carry;
                    r_shadow[r_fld] <= {r_shadow[r_fld][DATA_W-2:0], 1'b0};
                    if (r_bit == BIT_LAST) begin
                        r_bit <= '0;
                        if (r_fld == FLD_LAST) r_state <= S_COMMIT;
                        else                   r_fld   <= r_fld + 1'b1;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_seg   <= w_seg_next;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign seg  = r_seg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl (default parameters). Stimulus pushes
// the expected segment image and commit cycle for every accepted load; a
// negedge monitor pops on done and also tracks busy and seg hold behaviour.
module tb_seg7_display_ctrl;
    localparam int NF   = 4;
    localparam int D    = 2;
    localparam int W    = 32;
    localparam int SEGW = NF * D * 7;
    localparam int LAT  = NF * W + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            load = 1'b0;
    logic [NF*W-1:0] field_val = '0;
    logic            busy;
    logic            done;
    logic [SEGW-1:0] seg;

    seg7_display_ctrl #(.NUM_FIELDS(NF), .DIGITS_PER_FIELD(D), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .field_val(field_val),
        .busy(busy), .done(done), .seg(seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SEGW-1:0] seg;
        int              at_edge;
    } exp_t;

    exp_t            q[$];
    int              n_chk = 0;
    int              n_pass = 0;
    logic [SEGW-1:0] cur_seg;
    int              busy_start = 0;
    int              busy_end = 0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [6:0] enc(input int code);
        case (code)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [SEGW-1:0] all_zero();
        logic [SEGW-1:0] r;
        for (int i = 0; i < NF * D; i++) r[i*7 +: 7] = enc(0);
        return r;
    endfunction

    // Decimal reference: digits by division, dash when value >= 10^D.
    function automatic logic [SEGW-1:0] model(input logic [NF*W-1:0] fv);
        logic [SEGW-1:0] r;
        longint lim, v, p;
        int code;
        r = '0;
        lim = 1;
        for (int k = 0; k < D; k++) lim = lim * 10;
        for (int f = 0; f < NF; f++) begin
            v = longint'({32'd0, fv[f*W +: W]});
            p = 1;
            for (int d = 0; d < D; d++) begin
                if (v >= lim) code = 10;
                else begin
                    code = int'((v / p) % 10);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
                    if (d > 0 && v < p) code = 11;
`endif
                end
                r[(f*D+d)*7 +: 7] = enc(code);
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic logic [NF*W-1:0] pack(input int f3, input int f2, input int f1, input int f0);
        return {f3[31:0], f2[31:0], f1[31:0], f0[31:0]};
    endfunction

    // Called at a negedge; drives load for the next rising edge only.
    task automatic do_load(input logic [NF*W-1:0] v);
        int n;
        exp_t e;
        n = cyc + 1;
        field_val = v;
        load = 1'b1;
        if (n > busy_end) begin
            e.seg = model(v);
            e.at_edge = n + LAT;
            q.push_back(e);
            busy_start = n;
            busy_end = n + LAT;
        end
        @(negedge clk);
        load = 1'b0;
        field_val = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic load_at(input int edge_n, input logic [NF*W-1:0] v);
        while (cyc < edge_n - 1) @(negedge clk);
        do_load(v);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (cyc < busy_end && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Monitor: pop on done, check commit timing, held seg and busy.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_busy;
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1'b0, 64'(done), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc == e.at_edge, 64'(cyc), 64'(e.at_edge));
                    cur_seg = e.seg;
                end
            end else if (q.size() > 0 && cyc >= q[0].at_edge) begin
                chk("missing_done", 1'b0, 64'(cyc), 64'(q[0].at_edge));
                e = q.pop_front();
                cur_seg = e.seg;
            end
        end
        chk("seg", seg == cur_seg, 64'(seg), 64'(cur_seg));
        exp_busy = rst_n && (cyc >= busy_start) && (cyc < busy_end);
        chk("busy", busy == exp_busy, 64'(busy), 64'(exp_busy));
    end

    initial begin
        int na;
        int k;
        logic [NF*W-1:0] v;
        cur_seg = all_zero();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_seg", seg == all_zero(), 64'(seg), 64'(all_zero()));
        chk("reset_busy", busy == 1'b0, 64'(busy), 64'd0);
        chk("reset_done", done == 1'b0, 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversion with leading-zero field.
        do_load(pack(0, 99, 42, 7));
        wait_idle();

        // Overflowing fields next to normal ones.
        do_load(pack(9, 10, 12345, 100));
        wait_idle();

        // Loads during conversion and on the commit edge are dropped;
        // the cycle right after done accepts a new load.
        do_load(pack(11, 22, 33, 44));
        na = busy_start;
        load_at(na + 5, pack(1, 2, 3, 4));
        load_at(na + 128, pack(5, 6, 7, 8));
        load_at(na + 129, pack(98, 97, 96, 95));
        chk("done_at_commit", done == 1'b1, 64'(done), 64'd1);
        do_load(pack(3, 50, 0, 61));
        chk("busy_after_reload", busy == 1'b1, 64'(busy), 64'd1);
        wait_idle();

        // Random loads with random gaps, many landing while busy.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 160)) @(negedge clk);
            for (int f = 0; f < NF; f++)
                v[f*W +: W] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 120));
            do_load(v);
        end
        wait_idle();

        // Reset in the middle of a conversion.
        do_load(pack(42, 42, 42, 42));
        wait_idle();
        do_load(pack(17, 17, 17, 17));
        na = busy_start;
        while (cyc < na + 60) @(negedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        busy_start = 0;
        busy_end = 0;
        cur_seg = all_zero();
        #1;
        chk("abort_seg", seg == all_zero(), 64'(seg), 64'(all_zero()));
        chk("abort_busy", busy == 1'b0, 64'(busy), 64'd0);
        chk("abort_done", done == 1'b0, 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);

        // Leading-zero behaviour (blanked only when the macro is defined).
        do_load(pack(0, 5, 10, 99));
        k = 0;
        while (q.size() > 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q.size() == 0, 64'(q.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
